mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use clock clk and reset rst, where rst is synchronous and active-high.
REQ-002 Ports (all single-clock): clk in 1 clock; rst in 1 sync active-high reset.
REQ-003 req0 in 1 core request; we0 in 1 core write; addr0 in 8 core word address; wdata0 in 32 core write data.
REQ-004 gnt0 out 1 core grant pulse; rvalid0 out 1 core read-data valid pulse; rdata0 out 32 core read data.
REQ-005 req1 in 1 loader request; we1 in 1 loader write; addr1 in 8 loader word address; wdata1 in 32 loader write data.
REQ-006 gnt1 out 1 loader grant pulse; rvalid1 out 1 loader read-data valid pulse; rdata1 out 32 loader read data.
REQ-007 mce out 1 memory enable; mwre out 1 memory write enable; mad out 8 memory address; mdin out 32 memory write data; mdout in 32 memory read data (registered inside memory, valid one cycle after mce).

Function
REQ-008 FSM states SHALL be IDLE, ACCESS, RESP; IDLE is the only state that samples req0/req1.
REQ-009 In IDLE with any req high: pick winner per REQ-016/REQ-017; latch owner, we, addr, wdata; next state ACCESS; otherwise stay IDLE.
REQ-010 In ACCESS: mce=1, mwre=latched we, mad=latched addr, mdin=latched wdata; gnt of owner =1 for exactly this cycle; next state RESP.
REQ-011 In RESP: mce=0; for a read, capture mdout into rdata of owner at end of cycle; next state IDLE.
REQ-012 rvalid of owner SHALL pulse high one cycle, the cycle after RESP, only for reads; writes produce no rvalid.
REQ-013 Latency: req sampled in IDLE cycle T -> gnt at T+1 -> rvalid/rdata at T+3; one access per 3 cycles maximum.
REQ-014 rdataN SHALL hold its last captured value until the next read for port N; non-owner rdata never changes.
REQ-015 Requester SHALL hold req/we/addr/wdata stable until gnt and drop req the cycle after gnt; req during ACCESS/RESP is ignored; a req still high in the next IDLE is a new request.
REQ-016 Simultaneous req0 and req1 without REQ-024 macro: port 0 wins.
REQ-017 Single req: that port wins regardless of mode.
REQ-018 Outside ACCESS: mce=0, mwre=0; mad/mdin SHALL still be driven from latched values (no X).
REQ-019 gnt0 and gnt1 SHALL never be high together; rvalid0 and rvalid1 SHALL never be high together.

Reset
REQ-020 rst high at a clock edge SHALL force IDLE, regardless of current state; an in-flight transaction is abandoned with no gnt/rvalid afterward.
REQ-021 Reset values: gnt0=gnt1=rvalid0=rvalid1=0, mce=mwre=0, mad=0, mdin=0, rdata0=rdata1=0, latched owner=port 0.
REQ-022 A req held through reset release SHALL be sampled in the first IDLE cycle after rst falls.

Configuration
REQ-023 Macro MEM_ARB_RR_EN SHALL select the tie-break policy; nothing else changes.
REQ-024 With MEM_ARB_RR_EN defined: on simultaneous requests the port not granted last wins; last-granted pointer resets to port 1 (so port 0 wins first tie) and updates on every grant.
REQ-025 Without MEM_ARB_RR_EN: fixed priority port 0 (REQ-016); no pointer register is built.

Verification
REQ-026 Reset, then req0=1 we0=0 addr0=0x04 at T, memory word 4=0x00000013 -> gnt0 at T+1, mce=1 mad=0x04 at T+1, rvalid0=1 rdata0=0x00000013 at T+3, gnt1/rvalid1 stay 0.
REQ-027 req1=1 we1=1 addr1=0x10 wdata1=0xDEADBEEF, then port 0 read 0x10 -> mwre=1 mdin=0xDEADBEEF in ACCESS, no rvalid1, later rdata0=0xDEADBEEF.
REQ-028 req0 and req1 both held high for 4 grants, without macro -> grants 0,0,0,0 (port 1 starves); with MEM_ARB_RR_EN -> grants 0,1,0,1.
REQ-029 rst asserted during ACCESS of a port-1 read -> next cycle IDLE, all outputs at reset values, rvalid1 never pulses.
REQ-030 Back-to-back reads port 0 addr 0x00 then 0x01 (req re-asserted immediately) -> gnt0 at T+1 and T+4, rvalid0 at T+3 and T+6, rdata0 matches each word.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (core on port 0, loader on port 1),
// the shared single-port memory and the arbiter. The arbiter takes the slave
// modport. The requesters and the memory together take the master modport.
interface mem_arbiter_if;
    // core port
    logic        req0;
    logic        we0;
    logic [7:0]  addr0;
    logic [31:0] wdata0;
    logic        gnt0;
    logic        rvalid0;
    logic [31:0] rdata0;

    // loader port
    logic        req1;
    logic        we1;
    logic [7:0]  addr1;
    logic [31:0] wdata1;
    logic        gnt1;
    logic        rvalid1;
    logic [31:0] rdata1;

    // memory side
    logic        mce;
    logic        mwre;
    logic [7:0]  mad;
    logic [31:0] mdin;
    logic [31:0] mdout;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mdout,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mce, mwre, mad, mdin
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mdout,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mce, mwre, mad, mdin
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// Each access takes three cycles: IDLE samples the requests, ACCESS drives
// the memory and grants the winner, and RESP waits for the registered read
// data. Read data and rvalid are presented in the cycle after RESP.
// Tie-break: fixed priority to port 0 by default. Define MEM_ARB_RR_EN to
// alternate on ties instead, which adds a last-granted pointer.
module mem_arbiter (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      stateNext;

    logic        anyReq;
    logic        winner;
    logic        owner;
    logic        latchWe;
    logic [7:0]  latchAddr;
    logic [31:0] latchWdata;
    logic        rvalid0Q;
    logic        rvalid1Q;
    logic [31:0] rdata0Q;
    logic [31:0] rdata1Q;

    assign anyReq = bus.req0 | bus.req1;

`ifdef MEM_ARB_RR_EN
    logic lastGnt;

    // Remember which port was granted last. The reset value of port 1 makes
    // port 0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastGnt <= 1'b1;
        end else if (state == IDLE && anyReq) begin
            lastGnt <= winner;
        end
    end

    // On a tie, the port that was not granted last wins.
    always_comb begin
        winner = 1'b0;
        if (bus.req0 && bus.req1) begin
            winner = ~lastGnt;
        end else if (bus.req1) begin
            winner = 1'b1;
        end
    end
`else
    // Fixed priority: port 1 wins only when port 0 is not requesting.
    always_comb begin
        winner = bus.req1 & ~bus.req0;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and the memory strobes and grants, which are driven only in ACCESS.
    always_comb begin
        stateNext = state;
        bus.gnt0  = 1'b0;
        bus.gnt1  = 1'b0;
        bus.mce   = 1'b0;
        bus.mwre  = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                bus.mce   = 1'b1;
                bus.mwre  = latchWe;
                bus.gnt0  = ~owner;
                bus.gnt1  = owner;
                stateNext = RESP;
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Address and write data always come from the latched copy, so they are
    // never X, even outside ACCESS.
    assign bus.mad  = latchAddr;
    assign bus.mdin = latchWdata;

    // Latch the winning request in IDLE. The requester may drop req once granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= 1'b0;
            latchWe    <= 1'b0;
            latchAddr  <= 8'h00;
            latchWdata <= 32'h0000_0000;
        end else if (state == IDLE && anyReq) begin
            owner      <= winner;
            latchWe    <= winner ? bus.we1    : bus.we0;
            latchAddr  <= winner ? bus.addr1  : bus.addr0;
            latchWdata <= winner ? bus.wdata1 : bus.wdata0;
        end
    end

    // Capture read data at the end of RESP. The rdata of the other port is left untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0Q <= 1'b0;
            rvalid1Q <= 1'b0;
            rdata0Q  <= 32'h0000_0000;
            rdata1Q  <= 32'h0000_0000;
        end else begin
            rvalid0Q <= 1'b0;
            rvalid1Q <= 1'b0;
            if (state == RESP && !latchWe) begin
                if (owner) begin
                    rdata1Q  <= bus.mdout;
                    rvalid1Q <= 1'b1;
                end else begin
                    rdata0Q  <= bus.mdout;
                    rvalid0Q <= 1'b1;
                end
            end
        end
    end

    assign bus.rvalid0 = rvalid0Q;
    assign bus.rvalid1 = rvalid1Q;
    assign bus.rdata0  = rdata0Q;
    assign bus.rdata1  = rdata1Q;
endmodule
